// File: rtl/cpu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu_pkg : opcodes and instruction field positions for the CPU slice  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package cpu_pkg;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_BEQ   = 3'd2;
  localparam logic [2:0] OP_JMP   = 3'd3;
  localparam logic [2:0] OP_ADD   = 3'd4;
  localparam logic [2:0] OP_SUB   = 3'd5;
  localparam logic [2:0] OP_AND   = 3'd6;
  localparam logic [2:0] OP_OR    = 3'd7;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 29;
  localparam int RA0_HI    = 25;
  localparam int RA0_LO    = 21;
  localparam int RA1_HI    = 20;
  localparam int RA1_LO    = 16;
  localparam int RA2_HI    = 15;
  localparam int RA2_LO    = 11;
  localparam int ADDR_HI   = 15;
  localparam int ADDR_LO   = 0;

endpackage
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | data_mem : DEPTH x DATA_W word memory, async clear, sync write,      |
// |            async read.  Revision: 1.0                                 |
// +-----------------------------------------------------------------------+
module data_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[addr_i] = wdata_i;
    end
  end

  // Reset dominates a simultaneous write edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/decode_exec_mem.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | decode_exec_mem : decode, ALU/branch and data memory of the CPU      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module decode_exec_mem
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       inst_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [DATA_W-1:0] op0_i,
  input  logic [DATA_W-1:0] op1_i,
  input  logic              mem_we_i,
  output logic [2:0]        opcode_o,
  output logic [4:0]        reg_addr_0_o,
  output logic [4:0]        reg_addr_1_o,
  output logic [4:0]        reg_addr_2_o,
  output logic [15:0]       addr_o,
  output logic [DATA_W-1:0] alu_result_o,
  output logic              zero_o,
  output logic              branch_taken_o,
  output logic [PC_W-1:0]   change_pc_o,
  output logic [DATA_W-1:0] mem_rdata_o
);

  localparam int AW = $clog2(DEPTH);

  logic unused_inst_bits;
  logic mem_wr_en;

  always_comb begin
    opcode_o     = inst_i[OPCODE_HI:OPCODE_LO];
    reg_addr_0_o = inst_i[RA0_HI:RA0_LO];
    reg_addr_1_o = inst_i[RA1_HI:RA1_LO];
    reg_addr_2_o = inst_i[RA2_HI:RA2_LO];
    addr_o       = inst_i[ADDR_HI:ADDR_LO];
  end

  // Bits 28:26 carry no meaning in this ISA.
  assign unused_inst_bits = ^inst_i[28:26];

  always_comb begin
    alu_result_o   = '0;
    branch_taken_o = 1'b0;
    case (opcode_o)
      OP_BEQ:  branch_taken_o = (op0_i == op1_i);
      OP_JMP:  branch_taken_o = 1'b1;
      OP_ADD:  alu_result_o   = op0_i + op1_i;
      OP_SUB:  alu_result_o   = op0_i - op1_i;
      OP_AND:  alu_result_o   = op0_i & op1_i;
      OP_OR:   alu_result_o   = op0_i | op1_i;
      default: ;
    endcase
  end

  assign zero_o      = (alu_result_o == '0);
  assign change_pc_o = branch_taken_o ? addr_o[PC_W-1:0] : pc_i;
  assign mem_wr_en   = mem_we_i && (opcode_o == OP_STORE);

  data_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_data_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (mem_wr_en),
    .addr_i  (addr_o[AW-1:0]),
    .wdata_i (op0_i),
    .rdata_o (mem_rdata_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_decode_exec_mem.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_decode_exec_mem : directed scoreboard bench for decode_exec_mem   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_decode_exec_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_i;
  logic [7:0]  pc_i;
  logic [31:0] op0_i;
  logic [31:0] op1_i;
  logic        mem_we_i;
  logic [2:0]  opcode_o;
  logic [4:0]  reg_addr_0_o;
  logic [4:0]  reg_addr_1_o;
  logic [4:0]  reg_addr_2_o;
  logic [15:0] addr_o;
  logic [31:0] alu_result_o;
  logic        zero_o;
  logic        branch_taken_o;
  logic [7:0]  change_pc_o;
  logic [31:0] mem_rdata_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  decode_exec_mem #(
    .DATA_W (32),
    .DEPTH  (256),
    .PC_W   (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inst_i         (inst_i),
    .pc_i           (pc_i),
    .op0_i          (op0_i),
    .op1_i          (op1_i),
    .mem_we_i       (mem_we_i),
    .opcode_o       (opcode_o),
    .reg_addr_0_o   (reg_addr_0_o),
    .reg_addr_1_o   (reg_addr_1_o),
    .reg_addr_2_o   (reg_addr_2_o),
    .addr_o         (addr_o),
    .alu_result_o   (alu_result_o),
    .zero_o         (zero_o),
    .branch_taken_o (branch_taken_o),
    .change_pc_o    (change_pc_o),
    .mem_rdata_o    (mem_rdata_o)
  );

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] a,
                       input logic [31:0] b, input logic [7:0] pc);
    @(negedge clk);
    inst_i = inst;
    op0_i  = a;
    op1_i  = b;
    pc_i   = pc;
    #1;
  endtask

  task automatic store_word(input logic [15:0] addr, input logic [31:0] data);
    drive({3'd1, 13'd0, addr}, data, 32'd0, 8'd0);
    mem_we_i = 1'b1;
    @(posedge clk);
    #1;
    mem_we_i = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    inst_i   = '0;
    pc_i     = '0;
    op0_i    = '0;
    op1_i    = '0;
    mem_we_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state of memory
    drive(32'h0000_0010, 32'd0, 32'd0, 8'd0);
    expect_val("reset_rd_10", 32'h0);             check(mem_rdata_o);
    expect_val("reset_alu_load", 32'h0);          check(alu_result_o);

    // Decode fields
    drive(32'h20A2_0010, 32'd0, 32'd0, 8'd0);
    expect_val("dec_opcode", 32'd1);              check({29'd0, opcode_o});
    expect_val("dec_ra0", 32'd5);                 check({27'd0, reg_addr_0_o});
    expect_val("dec_ra1", 32'd2);                 check({27'd0, reg_addr_1_o});
    expect_val("dec_ra2", 32'd0);                 check({27'd0, reg_addr_2_o});
    expect_val("dec_addr", 32'h10);               check({16'd0, addr_o});
    expect_val("dec_ignored_bits", 32'd1);
    inst_i = 32'h3CA2_0010;
    #1;                                           check({29'd0, opcode_o});

    // STORE with read-during-write
    drive(32'h20A2_0010, 32'hDEAD_BEEF, 32'd0, 8'd0);
    mem_we_i = 1'b1;
    #1;
    expect_val("rdw_old", 32'h0);                 check(mem_rdata_o);
    @(posedge clk);
    #1;
    mem_we_i = 1'b0;
    expect_val("rdw_new", 32'hDEAD_BEEF);         check(mem_rdata_o);

    drive(32'h0000_0010, 32'd0, 32'd0, 8'd0);
    expect_val("load_10", 32'hDEAD_BEEF);         check(mem_rdata_o);
    drive(32'h0000_0110, 32'd0, 32'd0, 8'd0);
    expect_val("load_110_wrap", 32'hDEAD_BEEF);   check(mem_rdata_o);
    drive(32'h0000_0011, 32'd0, 32'd0, 8'd0);
    expect_val("load_11_empty", 32'h0);           check(mem_rdata_o);

    // ALU
    drive(32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 8'd0);
    expect_val("add_wrap", 32'h0);                check(alu_result_o);
    expect_val("add_wrap_zero", 32'd1);           check({31'd0, zero_o});
    drive(32'hA000_0000, 32'd5, 32'd7, 8'd0);
    expect_val("sub_5_7", 32'hFFFF_FFFE);         check(alu_result_o);
    expect_val("sub_zero", 32'd0);                check({31'd0, zero_o});
    drive(32'hA000_0000, 32'd0, 32'd1, 8'd0);
    expect_val("sub_0_1", 32'hFFFF_FFFF);         check(alu_result_o);
    drive(32'hC000_0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 8'd0);
    expect_val("and", 32'h00F0_00F0);             check(alu_result_o);
    drive(32'hE000_0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 8'd0);
    expect_val("or", 32'hFFF0_FFF0);              check(alu_result_o);
    expect_val("or_no_branch", 32'd0);            check({31'd0, branch_taken_o});

    // Write strobe with ADD opcode must not touch memory
    drive(32'h8000_0010, 32'h1234_5678, 32'd1, 8'd0);
    expect_val("add_addr_field", 32'h1234_5679);  check(alu_result_o);
    mem_we_i = 1'b1;
    @(posedge clk);
    #1;
    mem_we_i = 1'b0;
    drive(32'h0000_0010, 32'd0, 32'd0, 8'd0);
    expect_val("we_add_ignored", 32'hDEAD_BEEF);  check(mem_rdata_o);

    // Branches
    drive(32'h4000_0042, 32'd5, 32'd5, 8'h07);
    expect_val("beq_eq_taken", 32'd1);            check({31'd0, branch_taken_o});
    expect_val("beq_eq_pc", 32'h42);              check({24'd0, change_pc_o});
    expect_val("beq_alu_zero", 32'h0);            check(alu_result_o);
    drive(32'h4000_0042, 32'd5, 32'd6, 8'h07);
    expect_val("beq_ne_taken", 32'd0);            check({31'd0, branch_taken_o});
    expect_val("beq_ne_pc", 32'h07);              check({24'd0, change_pc_o});
    drive(32'h6000_0042, 32'd1, 32'd2, 8'h07);
    expect_val("jmp_taken", 32'd1);               check({31'd0, branch_taken_o});
    expect_val("jmp_pc", 32'h42);                 check({24'd0, change_pc_o});
    drive(32'h8000_0042, 32'd3, 32'd3, 8'h07);
    expect_val("add_no_branch_pc", 32'h07);       check({24'd0, change_pc_o});

    // Mid-run asynchronous reset with nonzero memory
    store_word(16'h0020, 32'hCAFE_F00D);
    drive(32'h0000_0020, 32'd0, 32'd0, 8'd0);
    expect_val("pre_reset_20", 32'hCAFE_F00D);    check(mem_rdata_o);
    #2;
    rst_n = 1'b0;
    #1;
    expect_val("async_reset_20", 32'h0);          check(mem_rdata_o);
    inst_i = 32'h0000_0010;
    #1;
    expect_val("async_reset_10", 32'h0);          check(mem_rdata_o);

    // Write edge while reset held: memory must stay clear
    drive(32'h2000_0030, 32'h5555_AAAA, 32'd0, 8'd0);
    mem_we_i = 1'b1;
    @(posedge clk);
    #1;
    mem_we_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h0000_0030, 32'd0, 32'd0, 8'd0);
    expect_val("reset_beats_write", 32'h0);       check(mem_rdata_o);

    // Memory is writable again after reset release
    store_word(16'h0030, 32'h0BAD_F00D);
    drive(32'h0000_0130, 32'd0, 32'd0, 8'd0);
    expect_val("post_reset_store", 32'h0BAD_F00D); check(mem_rdata_o);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
